// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Stall/flush controller for the 5-stage OTTER pipeline:
//               load-use stall, taken-branch flush and memory-wait freeze.
//               Optional macro HAZARD_PERF_CNT_EN builds the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  IF_ID_RS1,
    input  logic [4:0]  IF_ID_RS2,
    input  logic        IF_ID_useRS1,
    input  logic        IF_ID_useRS2,
    input  logic [4:0]  ID_EX_RD,
    input  logic        ID_EX_memRead,
    input  logic        EX_branchTaken,
    input  logic        MS_memReq,
    input  logic        MS_memAck,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MS_hold,
    output logic        MS_WB_bubble,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [15:0] c_timeout_val = 16'(MEM_TIMEOUT);
    localparam logic [15:0] c_wait_max    = 16'hFFFF;

    typedef enum logic [0:0] {
        c_run      = 1'b0,
        c_mem_wait = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_inc;
    logic        r_mem_timeout;
    logic        w_mem_stall;
    logic        w_load_use;

    // A request arriving while already waiting is a protocol error and is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_run:      if (MS_memReq && !MS_memAck) w_state_nxt = c_mem_wait;
            c_mem_wait: if (MS_memAck)               w_state_nxt = c_run;
        endcase
    end

    assign w_mem_stall = ((r_state == c_run) && MS_memReq && !MS_memAck) ||
                         ((r_state == c_mem_wait) && !MS_memAck);

    assign w_load_use = ID_EX_memRead && (ID_EX_RD != 5'd0) &&
                        ((IF_ID_useRS1 && (IF_ID_RS1 == ID_EX_RD)) ||
                         (IF_ID_useRS2 && (IF_ID_RS2 == ID_EX_RD)));

    assign w_wait_cnt_inc = (r_wait_cnt == c_wait_max) ? c_wait_max : r_wait_cnt + 16'd1;

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MS_hold   = 1'b0;
        MS_WB_bubble = 1'b0;
        if (RST) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            MS_WB_bubble = 1'b1;
        end else if (w_mem_stall) begin
            // EX is frozen, so a pending branch re-presents itself after release.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            EX_MS_hold   = 1'b1;
            MS_WB_bubble = 1'b1;
        end else if (EX_branchTaken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
        end else if (w_load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= c_run;
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_run) begin
                if (w_state_nxt == c_mem_wait) r_wait_cnt <= 16'd0;
            end else begin
                r_wait_cnt <= w_wait_cnt_inc;
                if (w_wait_cnt_inc == c_timeout_val) r_mem_timeout <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!PC_write)   r_stall_cycles <= r_stall_cycles + 32'd1;
            if (IF_ID_flush) r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Scoreboard bench for hazard_stall_unit: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  IF_ID_RS1 = '0, IF_ID_RS2 = '0, ID_EX_RD = '0;
    logic        IF_ID_useRS1 = 1'b0, IF_ID_useRS2 = 1'b0, ID_EX_memRead = 1'b0;
    logic        EX_branchTaken = 1'b0, MS_memReq = 1'b0, MS_memAck = 1'b0;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush;
    logic        EX_MS_hold, MS_WB_bubble, mem_timeout;
    logic [31:0] stall_cycles, flush_count;

    hazard_stall_unit #(.MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2),
        .IF_ID_useRS1(IF_ID_useRS1), .IF_ID_useRS2(IF_ID_useRS2),
        .ID_EX_RD(ID_EX_RD), .ID_EX_memRead(ID_EX_memRead),
        .EX_branchTaken(EX_branchTaken),
        .MS_memReq(MS_memReq), .MS_memAck(MS_memAck),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MS_hold(EX_MS_hold), .MS_WB_bubble(MS_WB_bubble),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pc_w, ifid_w, ifid_f, idex_f, hold, bub;
        logic        chk_regs, tmo;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: are we waiting on memory, how long, and the counters.
    bit          m_known   = 1'b0;
    bit          m_waiting = 1'b0;
    bit          m_tmo     = 1'b0;
    int          m_waited  = 0;
    logic [31:0] m_sc      = '0;
    logic [31:0] m_fc      = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic cyc(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit [4:0] rd, input bit mr,
                       input bit br, input bit req, input bit ack);
        exp_t e;
        bit   lu, stall;
        @(posedge CLK);
        #1;
        RST = rst; IF_ID_RS1 = rs1; IF_ID_RS2 = rs2; IF_ID_useRS1 = u1; IF_ID_useRS2 = u2;
        ID_EX_RD = rd; ID_EX_memRead = mr; EX_branchTaken = br; MS_memReq = req; MS_memAck = ack;

        lu    = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        stall = m_waiting ? !ack : (req && !ack);
        if (rst)        {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.hold, e.bub} = 6'b001101;
        else if (stall) {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.hold, e.bub} = 6'b000011;
        else if (br)    {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.hold, e.bub} = 6'b111100;
        else if (lu)    {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.hold, e.bub} = 6'b000100;
        else            {e.pc_w, e.ifid_w, e.ifid_f, e.idex_f, e.hold, e.bub} = 6'b110000;
        e.chk_regs = m_known;
        e.tmo      = m_tmo;
        e.sc       = m_sc;
        e.fc       = m_fc;
        q.push_back(e);

        if (rst) begin
            m_known = 1'b1; m_waiting = 1'b0; m_tmo = 1'b0; m_waited = 0;
            m_sc = '0; m_fc = '0;
        end else begin
            if (m_waiting) begin
                if (m_waited < 65535) m_waited++;
                if (m_waited == TO) m_tmo = 1'b1;
                if (ack) m_waiting = 1'b0;
            end else if (req && !ack) begin
                m_waiting = 1'b1;
                m_waited  = 0;
            end
`ifdef HAZARD_PERF_CNT_EN
            if (!e.pc_w)  m_sc = m_sc + 32'd1;
            if (e.ifid_f) m_fc = m_fc + 32'd1;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("PC_write",     {31'd0, PC_write},     {31'd0, e.pc_w});
            cmp("IF_ID_write",  {31'd0, IF_ID_write},  {31'd0, e.ifid_w});
            cmp("IF_ID_flush",  {31'd0, IF_ID_flush},  {31'd0, e.ifid_f});
            cmp("ID_EX_flush",  {31'd0, ID_EX_flush},  {31'd0, e.idex_f});
            cmp("EX_MS_hold",   {31'd0, EX_MS_hold},   {31'd0, e.hold});
            cmp("MS_WB_bubble", {31'd0, MS_WB_bubble}, {31'd0, e.bub});
            if (e.chk_regs) begin
                cmp("mem_timeout",  {31'd0, mem_timeout}, {31'd0, e.tmo});
                cmp("stall_cycles", stall_cycles, e.sc);
                cmp("flush_count",  flush_count,  e.fc);
            end
        end
    end

    initial begin
        bit rst, br, req, ack, u1, u2, mr;
        bit [4:0] rs1, rs2, rd;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // load-use on RS2, then bubble in EX
        cyc(0, 0, 5, 0, 1, 5, 1, 0, 0, 0);
        cyc(0, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 5, 0, 0, 5, 1, 0, 0, 0);
        cyc(0, 7, 0, 1, 0, 7, 1, 0, 0, 0);
        // branch plus load-use
        cyc(0, 0, 5, 0, 1, 5, 1, 1, 0, 0);
        // memory wait of three cycles with a branch waiting in EX
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        // request and ack together, stray ack
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // timeout
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // reset while waiting
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1  = 1'($urandom);
            u2  = 1'($urandom);
            mr  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 4) == 0);
            req = ($urandom_range(0, 6) == 0);
            ack = ($urandom_range(0, 4) == 0);
            cyc(rst, rs1, rs2, u1, u2, rd, mr, br, req, ack);
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline stall/flush controller for the 5-stage OTTER core; the back-pressure counterpart to the forwarding path. Forwarding resolves hazards by bypassing results, and this block handles the hazards that cannot be bypassed. It detects load-use dependencies in ID, kills wrong-path instructions on a taken branch or jump resolved in EX, and freezes the pipeline while a data-memory access in MEM waits for acknowledge. It drives the write-enable and flush controls of PC, IF_ID, ID_EX, EX_MS and MS_WB.

## Interface
- MEM_TIMEOUT, default 255: MEM_WAIT cycles before `mem_timeout` is raised; range 1–65535.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_ID_RS1, IF_ID_RS2  in  5  source registers of the instruction in ID.
- IF_ID_useRS1, IF_ID_useRS2  in  1  the ID instruction actually reads RS1 or RS2.
- ID_EX_RD  in  5  destination of the instruction in EX.
- ID_EX_memRead  in  1  the EX instruction is a load.
- EX_branchTaken  in  1  the branch or jump in EX redirects the PC.
- MS_memReq  in  1  single-cycle pulse on the first cycle a load or store occupies MEM.
- MS_memAck  in  1  data memory has completed the access; may coincide with `MS_memReq`.
- PC_write, IF_ID_write  out  1  register enables.
- IF_ID_flush, ID_EX_flush  out  1  replace the stage register contents with a NOP.
- EX_MS_hold  out  1  hold EX_MS.
- MS_WB_bubble  out  1  load a NOP into MS_WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles, flush_count  out  32  performance counters; see Configuration.

## Operation
- States: RUN and MEM_WAIT, held in a 1-bit register. `wait_cnt` is 16 bits.
- RUN → MEM_WAIT when `MS_memReq` is 1 and `MS_memAck` is 0.
- MEM_WAIT → RUN on `MS_memAck` = 1.
- `MS_memReq` seen while in MEM_WAIT is a protocol error and is ignored.
- `MS_memAck` seen in RUN without `MS_memReq` is ignored.
- `mem_stall` = (RUN and `MS_memReq` and not `MS_memAck`) or (MEM_WAIT and not `MS_memAck`).
- Load-use hazard `lu` = `ID_EX_memRead` and `ID_EX_RD` ≠ 0 and ((`IF_ID_useRS1` and `IF_ID_RS1` == `ID_EX_RD`) or (`IF_ID_useRS2` and `IF_ID_RS2` == `ID_EX_RD`)).
- Output priority, highest first:
  - `mem_stall`: `PC_write` = 0, `IF_ID_write` = 0, `EX_MS_hold` = 1, `MS_WB_bubble` = 1, both flushes 0. A pending `EX_branchTaken` is deferred; EX is frozen, so it is re-presented after release.
  - `EX_branchTaken`: `PC_write` = 1, `IF_ID_write` = 1, `IF_ID_flush` = 1, `ID_EX_flush` = 1. Any `lu` in the same cycle is discarded because the ID instruction is wrong-path.
  - `lu`: `PC_write` = 0, `IF_ID_write` = 0, `ID_EX_flush` = 1. This stalls exactly one cycle, because the bubble clears `ID_EX_memRead`.
  - Otherwise: `PC_write` = 1, `IF_ID_write` = 1, all other control outputs 0.
- `wait_cnt` is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating at 65535.
- `mem_timeout` sets when `wait_cnt` == MEM_TIMEOUT and stays set until RST.

## Timing
- Control outputs are combinational from the current state and inputs, with zero latency to the stage enables.
- State, `wait_cnt`, `mem_timeout` and the counters are registered.
- Outputs while RST = 1:
  - `PC_write` = 0, `IF_ID_write` = 0.
  - `IF_ID_flush` = 1, `ID_EX_flush` = 1.
  - `EX_MS_hold` = 0, `MS_WB_bubble` = 1.
- Values on the first edge with RST = 1: state = RUN, `wait_cnt` = 0, `mem_timeout` = 0, counters = 0.
- Reset during MEM_WAIT returns to RUN on that edge; the outstanding access is abandoned.
- Release cycle: the pipeline advances in the same cycle `MS_memAck` = 1, in both states.
- Minimum memory stall is 1 cycle, when the ack arrives on the cycle after the request.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
- Defined:
  - `stall_cycles` increments each non-reset cycle with `PC_write` = 0.
  - `flush_count` increments each non-reset cycle with `IF_ID_flush` = 1.
  - Both wrap modulo 2^32.
- Undefined: both ports remain in the port list, are tied to 0, and no counter flops are built.

## Test plan
- Load-use: `ID_EX_memRead` = 1, `ID_EX_RD` = 5, `IF_ID_RS2` = 5, `IF_ID_useRS2` = 1 -> one cycle of `PC_write` = 0 and `ID_EX_flush` = 1; next cycle, with the bubble in EX, `PC_write` = 1. Repeat with `ID_EX_RD` = 0 or `IF_ID_useRS2` = 0 -> no stall.
- Branch plus load-use in the same cycle -> `IF_ID_flush` = 1, `ID_EX_flush` = 1, `PC_write` = 1; `flush_count` +1 with the macro defined.
- Memory wait: `MS_memReq` pulse, then `MS_memAck` 3 cycles later -> freeze (`EX_MS_hold` = 1) for exactly 3 cycles, release on the ack cycle, state back to RUN; `stall_cycles` = 3.
- `MS_memReq` and `MS_memAck` in the same cycle -> no stall and no state change. `EX_branchTaken` during MEM_WAIT -> no flush until the release cycle.
- Timeout with MEM_TIMEOUT = 4 and no ack -> `mem_timeout` = 1 after the 4th wait cycle and stays 1 after the ack; RST clears it.
- Assert RST mid-MEM_WAIT -> reset output values during RST; RUN, `PC_write` = 1 and counters = 0 after release.
